// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: opcode and addressing-mode constants,
// instruction field positions and the fetch FSM state encoding.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_LOD  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_BRA  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ROT  = 4'h6;
    localparam logic [3:0] OP_SHF  = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] AM_IMM  = 4'h8;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selection: sequential increment, absolute branch to imm,
// or relative branch from the current PC, all modulo 2^PC_W.
module sisc_pc_next #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [15:0]     i_imm,
    input  logic            i_pc_sel,
    input  logic            i_br_sel,
    output logic [PC_W-1:0] o_pc_next
);

    logic [PC_W-1:0] w_imm;

    assign w_imm = PC_W'(i_imm);

    // Select between increment, absolute and relative targets
    always_comb begin
        o_pc_next = i_pc;
        if (!i_pc_sel) begin
            o_pc_next = i_pc + PC_W'(1);
        end else if (i_br_sel) begin
            o_pc_next = w_imm;
        end else begin
            o_pc_next = i_pc + w_imm;
        end
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch datapath: PC and IR registers, next-PC update and a req/ack
// instruction fetch with an ack timeout that substitutes a no-op word.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter int              IR_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
    parameter int              ACK_TIMEOUT = 15,
    parameter logic [IR_W-1:0] NOOP_WORD   = {IR_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    output logic [PC_W-1:0] im_addr,
    output logic            im_req,
    input  logic [IR_W-1:0] im_rdata,
    input  logic            im_ack,
    output logic [PC_W-1:0] pc_out,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic            fetch_busy,
    output logic            fetch_err
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_im_addr;
    logic [IR_W-1:0] r_ir;
    logic            r_im_req;
    logic            r_busy;
    logic            r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0] w_pc_next;

    sisc_pc_next #(.PC_W(PC_W)) u_pc_next (
        .i_pc      (r_pc),
        .i_imm     (imm),
        .i_pc_sel  (pc_sel),
        .i_br_sel  (br_sel),
        .o_pc_next (w_pc_next)
    );

    // Program counter: rst > pc_rst > pc_write, independent of fetch state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (pc_rst) begin
            r_pc <= RESET_PC;
        end else if (pc_write) begin
            r_pc <= w_pc_next;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Fetch FSM; in WAIT an abort beats an ack, and an ack beats the timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ir      <= {IR_W{1'b0}};
            r_im_req  <= 1'b0;
            r_im_addr <= {PC_W{1'b0}};
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ir_load && !pc_rst) begin
                        r_state   <= ST_WAIT;
                        r_im_addr <= r_pc;
                        r_im_req  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (pc_rst) begin
                        r_state  <= ST_IDLE;
                        r_im_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else if (im_ack) begin
                        r_state  <= ST_IDLE;
                        r_ir     <= im_rdata;
                        r_im_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_IDLE;
                        r_ir     <= NOOP_WORD;
                        r_im_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_err    <= 1'b1;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_im_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_cnt    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign pc_out     = r_pc;
    assign im_addr    = r_im_addr;
    assign im_req     = r_im_req;
    assign ir         = r_ir;
    assign fetch_busy = r_busy;
    assign fetch_err  = r_err;
    assign opcode     = r_ir[OPC_MSB:OPC_LSB];
    assign mm         = r_ir[MM_MSB:MM_LSB];
    assign imm        = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Scoreboard bench for sisc_fetch_unit: expected IR words are queued when a
// fetch outcome is driven and compared when the fetch completes.
module tb_sisc_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst, pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic [15:0] im_addr;
    logic        im_req;
    logic [31:0] im_rdata;
    logic        im_ack;
    logic [15:0] pc_out;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic [15:0] imm;
    logic        fetch_busy, fetch_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    sisc_fetch_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .im_addr(im_addr), .im_req(im_req), .im_rdata(im_rdata), .im_ack(im_ack),
        .pc_out(pc_out), .ir(ir), .opcode(opcode), .mm(mm), .imm(imm),
        .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input string tag);
        logic [31:0] e;
        chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, ir, e);
        end
    endtask

    task automatic start_fetch(input logic inc);
        ir_load  = 1'b1;
        pc_write = inc;
        pc_sel   = 1'b0;
        tick();
        ir_load  = 1'b0;
        pc_write = 1'b0;
        chk("req_rise", 32'(im_req), 32'd1);
        chk("busy_rise", 32'(fetch_busy), 32'd1);
    endtask

    task automatic ack_fetch(input logic [31:0] w);
        im_ack   = 1'b1;
        im_rdata = w;
        exp_q.push_back(w);
        tick();
        im_ack = 1'b0;
        chk("busy_fall", 32'(fetch_busy), 32'd0);
        chk("req_fall", 32'(im_req), 32'd0);
        pop_cmp("ir_ack");
    endtask

    task automatic jump(input logic absolute);
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_sel   = absolute;
        tick();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0;
        br_sel = 1'b0; ir_load = 1'b0; im_ack = 1'b0; im_rdata = 32'h0;
        tick();
        do_rst();
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", 32'(im_req), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'h0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // Basic fetch with PC increment in the load cycle, ack after two waits
        start_fetch(1'b1);
        chk("t1_addr", 32'(im_addr), 32'h0);
        chk("t1_pc", 32'(pc_out), 32'h1);
        tick();
        tick();
        chk("t1_busy_hold", 32'(fetch_busy), 32'd1);
        ack_fetch(32'h1800_0005);
        chk("t1_opcode", 32'(opcode), 32'h1);
        chk("t1_mm", 32'(mm), 32'h8);
        chk("t1_imm", 32'(imm), 32'h5);
        chk("t1_pc_after", 32'(pc_out), 32'h1);

        // Absolute to 0x10, relative wrap to 0, absolute to 0x40
        start_fetch(1'b0);
        chk("t2_addr1", 32'(im_addr), 32'h1);
        ack_fetch(32'h3000_0010);
        jump(1'b1);
        chk("t2_abs10", 32'(pc_out), 32'h0010);
        start_fetch(1'b0);
        chk("t2_addr10", 32'(im_addr), 32'h0010);
        ack_fetch(32'h3000_FFF0);
        jump(1'b0);
        chk("t2_rel_wrap", 32'(pc_out), 32'h0000);
        start_fetch(1'b0);
        ack_fetch(32'h3000_0040);
        jump(1'b1);
        chk("t2_abs40", 32'(pc_out), 32'h0040);

        // Increment wraps FFFF -> 0000
        start_fetch(1'b0);
        ack_fetch(32'h3000_FFFF);
        jump(1'b1);
        chk("t3_ffff", 32'(pc_out), 32'hFFFF);
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        chk("t3_wrap", 32'(pc_out), 32'h0000);

        // Abort by pc_rst; pc_write and ir_load in WAIT; stray ack in IDLE
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        start_fetch(1'b0);
        pc_write = 1'b1;
        ir_load  = 1'b1;
        tick();
        pc_write = 1'b0;
        ir_load  = 1'b0;
        chk("t5_addr_hold", 32'(im_addr), 32'h1);
        chk("t5_pc_in_wait", 32'(pc_out), 32'h2);
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        chk("t5_req", 32'(im_req), 32'd0);
        chk("t5_busy", 32'(fetch_busy), 32'd0);
        chk("t5_pc", 32'(pc_out), 32'h0);
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        chk("t5_stray_ir", ir, 32'h3000_FFFF);
        chk("t5_stray_busy", 32'(fetch_busy), 32'd0);

        // Ack on the final allowed wait cycle wins over the timeout
        start_fetch(1'b0);
        repeat (TO - 1) tick();
        chk("t6_busy_edge", 32'(fetch_busy), 32'd1);
        ack_fetch(32'hF000_0000);
        chk("t6_err", 32'(fetch_err), 32'd0);

        // No ack: timeout loads the no-op word and sets the sticky error
        start_fetch(1'b0);
        repeat (TO - 1) tick();
        chk("t4_busy_edge", 32'(fetch_busy), 32'd1);
        chk("t4_req_edge", 32'(im_req), 32'd1);
        exp_q.push_back(32'h0000_0000);
        tick();
        chk("t4_busy", 32'(fetch_busy), 32'd0);
        chk("t4_req", 32'(im_req), 32'd0);
        chk("t4_err", 32'(fetch_err), 32'd1);
        pop_cmp("t4_ir_noop");
        start_fetch(1'b0);
        ack_fetch(32'h5800_1234);
        chk("t4_err_sticky", 32'(fetch_err), 32'd1);
        do_rst();
        chk("t4_err_clr", 32'(fetch_err), 32'd0);
        chk("t4_ir_clr", ir, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
